alu_writeback: RTL

Write-back stage sitting directly downstream of the 32-bit ALU: it captures each ALU result and its carry/zero/negative/overflow flags, holds up to two pending writes in a small FIFO, and commits them to a 16-entry register file and a committed-flags register. Its two forwarding read ports supply the ALU's A and B operands. Values that are still pending in the FIFO are visible to dependent operations without waiting for commit.

---
 rtl/alu_writeback.sv | 120 ++++++++++++
 1 files changed

// File: rtl/alu_writeback.sv
// alu_writeback: write-back stage behind the 32-bit ALU.
// ALU results wait in a two-entry FIFO, then commit to a 16-entry register
// file and a committed-flags register. Two read ports forward values that are
// still pending so that dependent operations do not have to wait for commit.
module alu_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_we,
  input  logic              in_flag_we,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_carry,
  input  logic              in_zero,
  input  logic              in_negative,
  input  logic              in_overflow,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [3:0]        flags_q,
  output logic [15:0]       retire_cnt
);

  localparam int          NREGS = 2 ** ADDR_W;
  localparam logic [1:0]  FULL  = 2'(DEPTH);

  // One pending write: destination, enables, result and {c, z, n, v}.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic              we;
    logic              flag_we;
    logic [DATA_W-1:0] result;
    logic [3:0]        flags;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              yng_idx;
  logic [1:0]        count;
  logic [DATA_W-1:0] regs [NREGS];
  logic              do_accept;
  logic              do_commit;
  entry_t            head;

  // NOTE: in_ready depends only on registered count, never on in_valid, so the
  // upstream handshake cannot form a combinational loop through this stage.
  assign in_ready  = (count != FULL);
  assign do_accept = in_valid && in_ready;
  // An empty FIFO never commits, so accept+commit on empty is just an accept.
  assign do_commit = wb_en && (count != 2'd0);
  assign head      = fifo_q[rd_ptr];
  // The most recently written slot sits one behind the write pointer.
  assign yng_idx   = ~wr_ptr;

  // FIFO payload storage; validity comes solely from count, so no reset needed.
  // NOTE: only the payload memory is left unreset; the register file below must
  // read zero after reset, so it is cleared explicitly.
  always_ff @(posedge clk) begin
    if (do_accept)
      fifo_q[wr_ptr] <= '{rd: in_rd, we: in_we, flag_we: in_flag_we, result: in_result,
                          flags: {in_carry, in_zero, in_negative, in_overflow}};
  end

  // FIFO pointers and occupancy; reset drops every pending entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_accept) wr_ptr <= ~wr_ptr;
      if (do_commit) rd_ptr <= ~rd_ptr;
      case ({do_accept, do_commit})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Commit the head entry into the register file, flags and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      flags_q    <= '0;
      retire_cnt <= '0;
    end else if (do_commit) begin
      if (head.we && head.rd != '0) regs[head.rd] <= head.result;
      if (head.flag_we)             flags_q       <= head.flags;
      retire_cnt <= retire_cnt + 16'd1;
    end
  end

  // Forwarding read: r0 is zero, then youngest pending, then older, then regfile.
  function automatic logic [DATA_W-1:0] read_fwd(input logic [ADDR_W-1:0] addr);
    entry_t yng;
    entry_t old;
    yng = fifo_q[yng_idx];
    old = fifo_q[rd_ptr];
    if (addr == '0)                                return '0;
    if (count != 2'd0 && yng.we && yng.rd == addr) return yng.result;
    if (count == 2'd2 && old.we && old.rd == addr) return old.result;
    return regs[addr];
  endfunction

  // Both operand ports use the same forwarding priority.
  always_comb begin
    rs1_data = read_fwd(rs1_addr);
    rs2_data = read_fwd(rs2_addr);
  end

endmodule
